// File: rtl/sys_arr_tile_ctrl.sv
// Tile sequencer for the DSP systolic array: loads A/B operand tiles from a stream,
// starts the array, waits for done, then drains the result buffer as a stream.
module sys_arr_tile_ctrl #(
  parameter int unsigned BW = 2,
  parameter int unsigned N  = 4,
  localparam int unsigned BEATS = N * N / BW,
  localparam int unsigned AW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BW-1:0][31:0]  in_stream,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BW-1:0][31:0]  out_stream,
  output logic                 arr_wr_en,
  output logic                 arr_wr_sel,
  output logic [AW-1:0]        arr_wr_addr,
  output logic [BW-1:0][31:0]  arr_wr_data,
  output logic                 arr_start,
  input  logic                 arr_done,
  output logic [AW-1:0]        arr_rd_addr,
  input  logic [BW-1:0][31:0]  arr_rd_data,
  output logic                 busy,
  output logic [15:0]          tile_cnt,
  output logic [31:0]          compute_cycles
);

  typedef enum logic [2:0] {
    StIdle, StLoadA, StLoadB, StStart, StWait, StRd, StCap, StSend
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        k_q, k_d;
  logic [31:0]          cyc_q, cyc_d;
  logic [31:0]          compute_cycles_q, compute_cycles_d;
  logic [15:0]          tile_cnt_q, tile_cnt_d;
  logic [BW-1:0][31:0]  out_q, out_d;
  logic                 last_k;

  assign last_k = (k_q == AW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      k_q              <= '0;
      cyc_q            <= '0;
      compute_cycles_q <= '0;
      tile_cnt_q       <= '0;
      out_q            <= '0;
    end else begin
      state_q          <= state_d;
      k_q              <= k_d;
      cyc_q            <= cyc_d;
      compute_cycles_q <= compute_cycles_d;
      tile_cnt_q       <= tile_cnt_d;
      out_q            <= out_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    k_d              = k_q;
    cyc_d            = cyc_q;
    compute_cycles_d = compute_cycles_q;
    tile_cnt_d       = tile_cnt_q;
    out_d            = out_q;
    in_ready         = 1'b0;
    arr_wr_en        = 1'b0;
    arr_wr_sel       = 1'b0;
    arr_start        = 1'b0;
    out_valid        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StLoadA;
          k_d     = '0;
        end
      end
      StLoadA, StLoadB: begin
        in_ready   = 1'b1;
        arr_wr_en  = in_valid;
        arr_wr_sel = (state_q == StLoadB);
        if (in_valid) begin
          if (last_k) begin
            k_d     = '0;
            state_d = (state_q == StLoadA) ? StLoadB : StStart;
          end else begin
            k_d = k_q + AW'(1);
          end
        end
      end
      StStart: begin
        arr_start = 1'b1;
        cyc_d     = '0;
        state_d   = StWait;
      end
      StWait: begin
        cyc_d = cyc_q + 32'd1;
        // The done cycle itself counts toward the reported compute time.
        if (arr_done) begin
          compute_cycles_d = cyc_q + 32'd1;
          k_d              = '0;
          state_d          = StRd;
        end
      end
      StRd: begin
        state_d = StCap;
      end
      StCap: begin
        out_d   = arr_rd_data;
        state_d = StSend;
      end
      StSend: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_k) begin
            tile_cnt_d = tile_cnt_q + 16'd1;
            state_d    = StIdle;
          end else begin
            k_d     = k_q + AW'(1);
            state_d = StRd;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign arr_wr_addr    = k_q;
  assign arr_wr_data    = in_stream;
  assign arr_rd_addr    = k_q;
  assign out_stream     = out_q;
  assign busy           = (state_q != StIdle);
  assign tile_cnt       = tile_cnt_q;
  assign compute_cycles = compute_cycles_q;

endmodule

// File: tb/tb_sys_arr_tile_ctrl.sv
// Self-checking bench for sys_arr_tile_ctrl: scoreboarded operand writes and result beats,
// stall, stray-done, gapped-load and mid-drain reset scenarios.
module tb_sys_arr_tile_ctrl;

  localparam int unsigned BW    = 2;
  localparam int unsigned N     = 4;
  localparam int unsigned BEATS = 8;
  localparam int unsigned AW    = 3;

  logic                clk = 1'b0;
  logic                rst, en, in_valid, in_ready, out_valid, out_ready;
  logic [BW-1:0][31:0] in_stream, out_stream, arr_wr_data, arr_rd_data;
  logic                arr_wr_en, arr_wr_sel, arr_start, arr_done, busy;
  logic [AW-1:0]       arr_wr_addr, arr_rd_addr;
  logic [15:0]         tile_cnt;
  logic [31:0]         compute_cycles;

  logic [BW-1:0][31:0] res_mem [BEATS];

  logic [67:0] exp_wr[$], obs_wr[$];
  logic [63:0] exp_out[$], obs_out[$];

  int n_checks = 0;
  int n_fail = 0;
  int start_count = 0;
  int exp_starts = 0;
  int exp_tiles = 0;

  always #5 clk = ~clk;

  sys_arr_tile_ctrl #(.BW(BW), .N(N)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_stream(in_stream),
    .out_valid(out_valid), .out_ready(out_ready), .out_stream(out_stream),
    .arr_wr_en(arr_wr_en), .arr_wr_sel(arr_wr_sel), .arr_wr_addr(arr_wr_addr),
    .arr_wr_data(arr_wr_data), .arr_start(arr_start), .arr_done(arr_done),
    .arr_rd_addr(arr_rd_addr), .arr_rd_data(arr_rd_data),
    .busy(busy), .tile_cnt(tile_cnt), .compute_cycles(compute_cycles)
  );

  // Result buffer model: one-cycle read latency.
  always @(posedge clk) arr_rd_data <= res_mem[arr_rd_addr];

  always @(posedge clk) begin
    if (!rst && arr_wr_en) obs_wr.push_back({arr_wr_sel, arr_wr_addr, arr_wr_data});
    if (!rst && out_valid && out_ready) obs_out.push_back(out_stream);
    if (arr_start) start_count <= start_count + 1;
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; arr_done = 1'b0;
    in_stream = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid, arr_wr_en, arr_wr_sel, arr_start, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {in_ready, out_valid, arr_wr_en, arr_wr_sel, arr_start, busy});
    end
    n_checks++;
    if ({arr_wr_addr, arr_rd_addr} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_addr: got %b expected 0", {arr_wr_addr, arr_rd_addr});
    end
    n_checks++;
    if ({out_stream, tile_cnt, compute_cycles} !== 112'b0) begin
      n_fail++;
      $display("FAIL reset_regs: got out=%h tiles=%0d cyc=%0d expected 0",
               out_stream, tile_cnt, compute_cycles);
    end
    rst = 1'b0;
  endtask

  task automatic start_tile();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    #1;
    n_checks++;
    if ({busy, in_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_busy: got busy=%b in_ready=%b expected 1 1", busy, in_ready);
    end
  endtask

  task automatic load_tile(input bit gaps, input bit stray);
    logic [BW-1:0][31:0] beat;
    logic [67:0] e, o;
    int sz;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < int'(BEATS); k++) begin
        beat[0] = 32'(s * 100 + 2 * k);
        beat[1] = 32'(s * 100 + 2 * k + 1);
        in_valid = 1'b1;
        in_stream = beat;
        arr_done = stray && (s == 1) && (k == 3);
        exp_wr.push_back({s[0], k[AW-1:0], beat});
        #1;
        n_checks++;
        if ({in_ready, arr_wr_en, arr_wr_sel, arr_wr_addr} !== {2'b11, s[0], k[AW-1:0]}) begin
          n_fail++;
          $display("FAIL load_strobe: got rdy/en/sel/addr=%b expected %b",
                   {in_ready, arr_wr_en, arr_wr_sel, arr_wr_addr}, {2'b11, s[0], k[AW-1:0]});
        end
        @(posedge clk);
        @(negedge clk);
        arr_done = 1'b0;
        if (gaps && s == 0) begin
          in_valid = 1'b0;
          #1;
          n_checks++;
          if ({in_ready, arr_wr_en} !== 2'b10) begin
            n_fail++;
            $display("FAIL load_gap: got rdy/en=%b expected 10", {in_ready, arr_wr_en});
          end
          @(posedge clk);
          @(negedge clk);
        end
      end
    end
    in_valid = 1'b0;
    #1;
    exp_starts++;
    n_checks++;
    if (arr_start !== 1'b1) begin
      n_fail++;
      $display("FAIL start_pulse: got %b expected 1", arr_start);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (arr_start !== 1'b0) begin
      n_fail++;
      $display("FAIL start_once: got %b expected 0", arr_start);
    end
    sz = exp_wr.size();
    n_checks++;
    if (obs_wr.size() != sz) begin
      n_fail++;
      $display("FAIL wr_count: got %0d writes expected %0d", obs_wr.size(), sz);
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front();
      o = obs_wr.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wr_data: got %h expected %h", o, e);
      end
    end
    exp_wr.delete();
    obs_wr.delete();
  endtask

  task automatic run_compute(input int done_at);
    logic [BW-1:0][31:0] e;
    for (int c = 1; c <= done_at; c++) begin
      arr_done = (c == done_at);
      #1;
      n_checks++;
      if ({busy, out_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL wait_hold: got busy/out_valid=%b expected 10", {busy, out_valid});
      end
      @(posedge clk);
      @(negedge clk);
    end
    arr_done = 1'b0;
    for (int k = 0; k < int'(BEATS); k++) begin
      e[0] = 32'(1000 + k);
      e[1] = 32'(2000 + k);
      exp_out.push_back(e);
    end
    #1;
    n_checks++;
    if (compute_cycles !== 32'(done_at)) begin
      n_fail++;
      $display("FAIL compute_cycles: got %0d expected %0d", compute_cycles, done_at);
    end
    n_checks++;
    if (start_count != exp_starts) begin
      n_fail++;
      $display("FAIL start_count: got %0d expected %0d", start_count, exp_starts);
    end
  endtask

  task automatic drain(input int stall_beat, input int rst_beat);
    int waits;
    logic [BW-1:0][31:0] held;
    logic [63:0] e, o;
    for (int b = 0; b < int'(BEATS); b++) begin
      waits = 0;
      #1;
      while (out_valid !== 1'b1 && waits < 20) begin
        waits++;
        @(posedge clk);
        @(negedge clk);
        #1;
      end
      n_checks++;
      if (waits != 2) begin
        n_fail++;
        $display("FAIL drain_latency: beat %0d got %0d idle cycles expected 2", b, waits);
      end
      if (waits >= 20) return;
      if (b == rst_beat) begin
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        exp_tiles = 0;
        n_checks++;
        if ({out_valid, busy, tile_cnt, compute_cycles} !== 50'b0) begin
          n_fail++;
          $display("FAIL mid_reset: got valid=%b busy=%b tiles=%0d cyc=%0d expected 0",
                   out_valid, busy, tile_cnt, compute_cycles);
        end
        n_checks++;
        if (obs_out.size() != b) begin
          n_fail++;
          $display("FAIL mid_reset_count: got %0d beats expected %0d", obs_out.size(), b);
        end
        while (obs_out.size() > 0) begin
          e = exp_out.pop_front();
          o = obs_out.pop_front();
          n_checks++;
          if (o !== e) begin
            n_fail++;
            $display("FAIL out_data: got %h expected %h", o, e);
          end
        end
        exp_out.delete();
        return;
      end
      if (b == stall_beat) begin
        held = out_stream;
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk);
          @(negedge clk);
          #1;
          n_checks++;
          if ({out_valid, out_stream} !== {1'b1, held}) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%b data=%h expected 1 %h",
                     out_valid, out_stream, held);
          end
        end
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
    exp_tiles++;
    #1;
    n_checks++;
    if ({busy, out_valid, tile_cnt} !== {2'b00, 16'(exp_tiles)}) begin
      n_fail++;
      $display("FAIL tile_done: got busy=%b valid=%b tiles=%0d expected 0 0 %0d",
               busy, out_valid, tile_cnt, exp_tiles);
    end
    n_checks++;
    if (obs_out.size() != int'(BEATS)) begin
      n_fail++;
      $display("FAIL out_count: got %0d beats expected %0d", obs_out.size(), BEATS);
    end
    while (exp_out.size() > 0 && obs_out.size() > 0) begin
      e = exp_out.pop_front();
      o = obs_out.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL out_data: got %h expected %h", o, e);
      end
    end
    exp_out.delete();
    obs_out.delete();
  endtask

  task automatic test_basic_with_stall();
    start_tile();
    load_tile(1'b0, 1'b0);
    run_compute(10);
    drain(3, -1);
  endtask

  task automatic test_gaps_stray_done();
    start_tile();
    load_tile(1'b1, 1'b1);
    run_compute(10);
    drain(-1, -1);
  endtask

  task automatic test_reset_in_send();
    start_tile();
    load_tile(1'b0, 1'b0);
    run_compute(10);
    drain(-1, 5);
  endtask

  task automatic test_recovery();
    start_tile();
    load_tile(1'b0, 1'b0);
    run_compute(7);
    drain(-1, -1);
  endtask

  initial begin
    for (int k = 0; k < int'(BEATS); k++) begin
      res_mem[k][0] = 32'(1000 + k);
      res_mem[k][1] = 32'(2000 + k);
    end
    test_reset();
    test_basic_with_stall();
    test_gaps_stray_done();
    test_reset_in_send();
    test_recovery();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_arr_tile_ctrl.md
# sys_arr_tile_ctrl

Tile sequencer for the DSP systolic array. It accepts one N×N A-tile and one N×N B-tile as AXI-Stream beats of BW 32-bit words each, and writes them into the array's operand buffers. It then pulses the array start, waits for the array's done, reads the N×N result buffer back, and emits it as AXI-Stream beats under backpressure. It sits between the input/output stream interfaces and the array core, and keeps tile and compute-cycle counters for software.

## Interface
Parameters:
- BW, 2, 32-bit words per stream beat; N*N must be divisible by BW.
- N, 4, array dimension (tile is N×N words).
- Derived: BEATS = N*N/BW; AW = max(1, $clog2(BEATS)).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  permits a new tile to start; sampled only in IDLE.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_stream  in  [BW-1:0][31:0]  input beat words.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_stream  out  [BW-1:0][31:0]  output beat words.
- arr_wr_en  out  1  operand-buffer write strobe.
- arr_wr_sel  out  1  0 = A buffer, 1 = B buffer.
- arr_wr_addr  out  AW  operand beat index.
- arr_wr_data  out  [BW-1:0][31:0]  operand write data.
- arr_start  out  1  one-cycle compute start pulse.
- arr_done  in  1  array finished; honoured only in WAIT.
- arr_rd_addr  out  AW  result beat index.
- arr_rd_data  in  [BW-1:0][31:0]  result data, valid one cycle after arr_rd_addr.
- busy  out  1  state != IDLE.
- tile_cnt  out  16  completed tiles; wraps 0xFFFF→0.
- compute_cycles  out  32  WAIT cycles spent by the most recent tile.

## Operation
- States: IDLE, LOAD_A, LOAD_B, START, WAIT, RD, CAP, SEND. Beat counter k (AW bits) is shared by the load and drain phases.
- IDLE:
  - en=1 → LOAD_A with k=0; otherwise stay.
  - en is ignored in every other state.
- LOAD_A / LOAD_B:
  - in_ready=1.
  - arr_wr_en = in_valid (combinational); arr_wr_addr = k; arr_wr_data = in_stream; arr_wr_sel = 0 in LOAD_A, 1 in LOAD_B.
  - On each accepted beat, k++.
  - When the accepted beat has k == BEATS-1: k←0, and LOAD_A→LOAD_B or LOAD_B→START.
  - BEATS == 1 is legal: each load state consumes exactly one beat.
- START: arr_start=1 for exactly this cycle; compute counter cleared to 0; → WAIT.
- WAIT:
  - Compute counter increments every cycle.
  - When arr_done=1: compute_cycles ← counter+1 (includes the done cycle); k←0; → RD.
  - arr_done asserted in any other state is ignored.
- RD: arr_rd_addr = k; → CAP.
- CAP: out_stream register ← arr_rd_data; → SEND.
- SEND:
  - out_valid=1; out_stream is held stable until the handshake.
  - On out_ready=1: if k == BEATS-1, then tile_cnt++ and → IDLE; else k++ and → RD.
- Idle values of strobes outside their owning states: in_ready, arr_wr_en, arr_start and out_valid are 0; arr_rd_addr = k.
- Words inside a beat keep lane order: lane i of a beat maps to lane i of the buffer entry.

## Timing
- Reset values: state IDLE, k=0, in_ready=0, out_valid=0, out_stream=0, arr_wr_en=0, arr_wr_sel=0, arr_wr_addr=0, arr_start=0, arr_rd_addr=0, busy=0, tile_cnt=0, compute_cycles=0.
- Reset asserted mid-tile:
  - Return to IDLE next edge; partial loads are discarded.
  - Counters clear.
  - out_valid drops without a handshake. This is the only permitted exception to the AXI hold rule.
- Load throughput is 1 beat/cycle, with zero-cycle latency from an accepted beat to arr_wr_en.
- The last B beat is accepted in cycle t; arr_start is high in cycle t+1.
- Drain:
  - 3 cycles/beat minimum (RD, CAP, SEND).
  - The first out_valid arrives 3 cycles after the arr_done cycle.
  - Backpressure extends SEND indefinitely with no data change.
- busy rises the cycle after en is sampled in IDLE, and falls the cycle after the final output handshake.

## Test plan
- N=4, BW=2 (BEATS=8); assert rst for 2 cycles → every output at its reset value; hold en=1 → busy=1 on the next cycle, in_ready=1.
- Stream A beats {2k, 2k+1} for k=0..7, then B beats {100+2k, 101+2k}, in_valid continuous → arr_wr_addr 0..7 with sel=0 then 0..7 with sel=1; arr_start pulses exactly once, one cycle after the last B beat.
- arr_done rises on the 10th WAIT cycle → compute_cycles=10; result beats {1000+k, 2000+k} are read back in order, and out_stream beat k = {1000+k, 2000+k}.
- out_ready held low for 5 cycles on beat 3 → out_valid stays 1 and out_stream is unchanged throughout; all 8 beats are delivered once, in order; tile_cnt=1; busy=0 afterwards.
- Gaps in in_valid (on alternate cycles) during LOAD_A; pulse arr_done during LOAD_B → no spurious writes; the stray done is ignored and the controller still waits in WAIT for a real done.
- Assert rst during the SEND of beat 5 → next cycle state IDLE, out_valid=0, tile_cnt=0; a full tile run afterwards completes normally.
